// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter for the shared memory data port: ACCEPT -> ACCESS -> RESPONSE.
// Optional ownership lock for atomic read-modify-write is compiled in with MEM_ARB_LOCK_EN.
module mem_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter bit          M0_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic [2:0]        m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_lock,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic [2:0]        m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned WE_W = 3;

    typedef struct packed {
        logic [WE_W-1:0]   we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } beat_t;

    logic       last_owner;
    logic [1:0] rr_gnt;
    logic [1:0] gnt;
    logic       accept;
    logic       win;
    beat_t      sel_beat;
    logic       acc_valid;
    logic       acc_owner;
    beat_t      acc_beat;

    // Round-robin: on contention the master that did not win last time is granted.
    always_comb begin
        rr_gnt = {m1_req, m0_req};
        if (m0_req && m1_req) begin
            rr_gnt = last_owner ? 2'b01 : 2'b10;
        end
    end

`ifdef MEM_ARB_LOCK_EN
    logic lock_act;
    logic lock_own;
    logic sel_lock;

    always_comb begin
        gnt = rr_gnt;
        if (lock_act) begin
            gnt = lock_own ? {m1_req, 1'b0} : {1'b0, m0_req};
        end
    end

    assign sel_lock = win ? m1_lock : m0_lock;

    // Lock is taken by a locked beat and dropped by the owner's next unlocked beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_act <= 1'b0;
            lock_own <= 1'b0;
        end else if (accept) begin
            if (lock_act) begin
                if (!sel_lock) begin
                    lock_act <= 1'b0;
                end
            end else if (sel_lock) begin
                lock_act <= 1'b1;
                lock_own <= win;
            end
        end
    end
`else
    logic unused_lock;
    assign unused_lock = m0_lock ^ m1_lock;
    assign gnt = rr_gnt;
`endif

    assign m0_gnt = gnt[0];
    assign m1_gnt = gnt[1];
    assign accept = |gnt;
    assign win    = gnt[1];

    always_comb begin
        sel_beat = '0;
        if (win) begin
            sel_beat.we    = m1_we;
            sel_beat.addr  = m1_addr;
            sel_beat.wdata = m1_wdata;
        end else begin
            sel_beat.we    = m0_we;
            sel_beat.addr  = m0_addr;
            sel_beat.wdata = m0_wdata;
        end
    end

    // ACCESS stage: idle cycles present an all-zero beat to memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_owner <= M0_FIRST ? 1'b1 : 1'b0;
            acc_valid  <= 1'b0;
            acc_owner  <= 1'b0;
            acc_beat   <= '0;
        end else begin
            acc_valid <= accept;
            acc_owner <= win;
            acc_beat  <= accept ? sel_beat : '0;
            if (accept) begin
                last_owner <= win;
            end
        end
    end

    assign mem_addr  = acc_beat.addr;
    assign mem_we    = acc_beat.we;
    assign mem_wdata = acc_beat.wdata;

    // RESPONSE stage: only the owner sees rvalid; writes return zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
        end else begin
            m0_rvalid <= acc_valid && !acc_owner;
            m1_rvalid <= acc_valid && acc_owner;
            m0_rdata  <= (acc_valid && !acc_owner && acc_beat.we == '0) ? mem_rdata : '0;
            m1_rdata  <= (acc_valid && acc_owner && acc_beat.we == '0) ? mem_rdata : '0;
        end
    end

endmodule
